// File: rtl/controller_interface.sv
// Serial reader for two NES-style pads: latches both, shifts 8 bits out of each, commits active-high bytes.
// Optional `CONTROLLER_DEBOUNCE_EN: a byte is committed only after two identical consecutive frames.
module controller_interface #(
    parameter int HALF_PERIOD = 76
) (
    input  logic       gpu_clk,
    input  logic       rst,
    input  logic       start_fetch_i,
    output logic       latch_o,
    output logic       controller_clk_o,
    input  logic       data_1_i,
    input  logic       data_2_i,
    output logic [7:0] controller_1_o,
    output logic [7:0] controller_2_o,
    output logic       updated_o,
    output logic       busy_o,
    input  logic       SELECT_controller_1_i,
    input  logic       SELECT_controller_2_i,
    output logic [7:0] data_o
);

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_READ, S_PULSE, S_DONE} state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [8:0] r_phase_cnt;
    logic [2:0] r_bit_idx;
    logic [7:0] r_sr_1;
    logic [7:0] r_sr_2;
    logic       r_start_prev;
    logic       r_d1_meta, r_d1_sync;
    logic       r_d2_meta, r_d2_sync;
    logic       r_latch, r_cclk, r_updated, r_busy;
    logic [7:0] r_ctrl_1, r_ctrl_2;
    logic       w_trigger;
    logic       w_phase_last;

    // Pad data is asynchronous to gpu_clk; plain two-flop synchronizers.
    always_ff @(posedge gpu_clk) begin
        r_d1_meta <= data_1_i;
        r_d1_sync <= r_d1_meta;
        r_d2_meta <= data_2_i;
        r_d2_sync <= r_d2_meta;
    end

    assign w_trigger    = start_fetch_i && !r_start_prev && (r_state == S_IDLE);
    assign w_phase_last = (r_state == S_LATCH) ? (r_phase_cnt == 9'(2 * HALF_PERIOD - 1))
                                               : (r_phase_cnt == 9'(HALF_PERIOD - 1));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_trigger) w_next_state = S_LATCH;
            S_LATCH: if (w_phase_last) w_next_state = S_READ;
            S_READ:  if (w_phase_last) w_next_state = (r_bit_idx == 3'd7) ? S_DONE : S_PULSE;
            S_PULSE: if (w_phase_last) w_next_state = S_READ;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge gpu_clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_start_prev <= 1'b0;
            r_phase_cnt  <= '0;
            r_bit_idx    <= '0;
            r_latch      <= 1'b0;
            r_cclk       <= 1'b1;
            r_updated    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_start_prev <= start_fetch_i;
            if (w_next_state != r_state || r_state == S_IDLE)
                r_phase_cnt <= '0;
            else
                r_phase_cnt <= r_phase_cnt + 9'd1;
            if (r_state == S_LATCH && w_phase_last)
                r_bit_idx <= '0;
            else if (r_state == S_PULSE && w_phase_last)
                r_bit_idx <= r_bit_idx + 3'd1;
            // Outputs follow the next state so they line up with r_state and stay glitch-free.
            r_latch   <= (w_next_state == S_LATCH);
            r_cclk    <= (w_next_state != S_PULSE);
            r_updated <= (w_next_state == S_DONE);
            r_busy    <= (w_next_state != S_IDLE);
        end
    end

    always_ff @(posedge gpu_clk) begin
        if (rst) begin
            r_sr_1 <= '0;
            r_sr_2 <= '0;
        end else if (r_state == S_READ && w_phase_last) begin
            r_sr_1 <= {r_sr_1[6:0], ~r_d1_sync};
            r_sr_2 <= {r_sr_2[6:0], ~r_d2_sync};
        end
    end

`ifdef CONTROLLER_DEBOUNCE_EN
    logic [7:0] r_raw_prev_1;
    logic [7:0] r_raw_prev_2;

    always_ff @(posedge gpu_clk) begin
        if (rst) begin
            r_raw_prev_1 <= '0;
            r_raw_prev_2 <= '0;
            r_ctrl_1     <= '0;
            r_ctrl_2     <= '0;
        end else if (r_state == S_DONE) begin
            r_raw_prev_1 <= r_sr_1;
            r_raw_prev_2 <= r_sr_2;
            if (r_sr_1 == r_raw_prev_1) r_ctrl_1 <= r_sr_1;
            if (r_sr_2 == r_raw_prev_2) r_ctrl_2 <= r_sr_2;
        end
    end
`else
    always_ff @(posedge gpu_clk) begin
        if (rst) begin
            r_ctrl_1 <= '0;
            r_ctrl_2 <= '0;
        end else if (r_state == S_DONE) begin
            r_ctrl_1 <= r_sr_1;
            r_ctrl_2 <= r_sr_2;
        end
    end
`endif

    always_comb begin
        if (SELECT_controller_1_i)
            data_o = r_ctrl_1;
        else if (SELECT_controller_2_i)
            data_o = r_ctrl_2;
        else
            data_o = 'x;
    end

    assign latch_o          = r_latch;
    assign controller_clk_o = r_cclk;
    assign updated_o        = r_updated;
    assign busy_o           = r_busy;
    assign controller_1_o   = r_ctrl_1;
    assign controller_2_o   = r_ctrl_2;

endmodule
